// File: rtl/csa_pipe_adder.sv
// Pipelined carry-select adder/subtractor with valid/ready flow control.
// Each pipeline stage resolves one WIDTH/STAGES-bit slice using BLK-bit dual-sum blocks.
module csa_pipe_adder #(
    parameter int unsigned WIDTH  = 64,
    parameter int unsigned BLK    = 4,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned S    = WIDTH / STAGES;
    localparam int unsigned NB   = S / BLK;
    localparam int unsigned LAST = STAGES - 1;

    if (STAGES < 1 || STAGES > 8 || (WIDTH % (BLK * STAGES)) != 0) begin : g_bad_params
        $error("csa_pipe_adder: illegal WIDTH/BLK/STAGES combination");
    end

    // One slice: every block precomputes both carry-in cases, a mux ripple picks the real one.
    function automatic logic [S:0] slice_add(input logic [S-1:0] x, input logic [S-1:0] y,
                                             input logic ci);
        logic [S-1:0] r;
        logic         c;
        logic [BLK:0] s0;
        logic [BLK:0] s1;
        r = '0;
        c = ci;
        for (int j = 0; j < int'(NB); j++) begin
            s0 = {1'b0, x[j*BLK +: BLK]} + {1'b0, y[j*BLK +: BLK]};
            s1 = {1'b0, x[j*BLK +: BLK]} + {1'b0, y[j*BLK +: BLK]} + {{BLK{1'b0}}, 1'b1};
            r[j*BLK +: BLK] = c ? s1[BLK-1:0] : s0[BLK-1:0];
            c = c ? s1[BLK] : s0[BLK];
        end
        return {c, r};
    endfunction

    logic [STAGES-1:0]            v_q, v_d, load;
    logic [STAGES-1:0]            c_q, c_d;
    logic [STAGES-1:0][WIDTH-1:0] sum_q, sum_d;
    logic [STAGES-1:0][WIDTH-1:0] a_q, a_d;
    logic [STAGES-1:0][WIDTH-1:0] b_q, b_d;
    logic                         ovf_q, ovf_d;

    // Load conditions chain backwards from the output so empty stages absorb bubbles.
    always_comb begin
        logic nxt;
        load = '0;
        nxt  = !v_q[LAST] || out_ready;
        load[LAST] = nxt;
        for (int k = int'(LAST) - 1; k >= 0; k--) begin
            nxt     = !v_q[k] || nxt;
            load[k] = nxt;
        end
    end

    always_comb begin
        logic             src_v;
        logic             src_c;
        logic [WIDTH-1:0] src_a;
        logic [WIDTH-1:0] src_b;
        logic [WIDTH-1:0] src_sum;
        logic [S:0]       res;
        int               p;
        v_d   = v_q;
        c_d   = c_q;
        sum_d = sum_q;
        a_d   = a_q;
        b_d   = b_q;
        ovf_d = ovf_q;
        for (int k = 0; k < int'(STAGES); k++) begin
            p = (k == 0) ? 0 : k - 1;
            if (k == 0) begin
                src_v   = in_valid;
                src_a   = a;
                src_b   = sub ? ~b : b;
                src_c   = cin ^ sub;
                src_sum = '0;
            end else begin
                src_v   = v_q[p];
                src_a   = a_q[p];
                src_b   = b_q[p];
                src_c   = c_q[p];
                src_sum = sum_q[p];
            end
            res = slice_add(src_a[k*S +: S], src_b[k*S +: S], src_c);
            if (load[k]) begin
                v_d[k] = src_v;
                if (src_v) begin
                    sum_d[k]           = src_sum;
                    sum_d[k][k*S +: S] = res[S-1:0];
                    c_d[k]             = res[S];
                    a_d[k]             = src_a;
                    b_d[k]             = src_b;
                    // Carry into the MSB is recovered as a^b^sum at that bit.
                    if (k == int'(LAST)) begin
                        ovf_d = src_a[WIDTH-1] ^ src_b[WIDTH-1] ^ res[S-1] ^ res[S];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q   <= '0;
            c_q   <= '0;
            sum_q <= '0;
            a_q   <= '0;
            b_q   <= '0;
            ovf_q <= 1'b0;
        end else begin
            v_q   <= v_d;
            c_q   <= c_d;
            sum_q <= sum_d;
            a_q   <= a_d;
            b_q   <= b_d;
            ovf_q <= ovf_d;
        end
    end

    assign in_ready  = load[0];
    assign out_valid = v_q[LAST];
    assign sum       = sum_q[LAST];
    assign cout      = c_q[LAST];
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_csa_pipe_adder.sv
// Directed and random checks of csa_pipe_adder: latency, flow control, reset, parameter sweep.
module tb_csa_pipe_adder;

    localparam int MAIN_ST = 2;
    localparam int N_SWEEP = 1000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic        cin, sub, cout, ovf;
    logic [63:0] a, b, sum;

    logic        s1_in_ready, s1_valid, s1_cout, s1_ovf;
    logic [31:0] s1_sum;
    logic        s2_in_ready, s2_valid, s2_cout, s2_ovf;
    logic [15:0] s2_sum;
    logic        s3_in_ready, s3_valid, s3_cout, s3_ovf;
    logic [63:0] s3_sum;

    logic        sw_valid [4];
    logic        sw_cout  [4];
    logic        sw_ovf   [4];
    logic [63:0] sw_sum   [4];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    csa_pipe_adder u0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
        .cin(cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
        .cout(cout), .ovf(ovf)
    );

    csa_pipe_adder #(.WIDTH(32), .BLK(8), .STAGES(4)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s1_in_ready), .a(a[31:0]),
        .b(b[31:0]), .cin(cin), .sub(sub), .out_valid(s1_valid), .out_ready(1'b1),
        .sum(s1_sum), .cout(s1_cout), .ovf(s1_ovf)
    );

    csa_pipe_adder #(.WIDTH(16), .BLK(4), .STAGES(1)) u2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s2_in_ready), .a(a[15:0]),
        .b(b[15:0]), .cin(cin), .sub(sub), .out_valid(s2_valid), .out_ready(1'b1),
        .sum(s2_sum), .cout(s2_cout), .ovf(s2_ovf)
    );

    csa_pipe_adder #(.WIDTH(64), .BLK(2), .STAGES(8)) u3 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s3_in_ready), .a(a), .b(b),
        .cin(cin), .sub(sub), .out_valid(s3_valid), .out_ready(1'b1), .sum(s3_sum),
        .cout(s3_cout), .ovf(s3_ovf)
    );

    assign sw_valid[0] = out_valid;
    assign sw_valid[1] = s1_valid;
    assign sw_valid[2] = s2_valid;
    assign sw_valid[3] = s3_valid;
    assign sw_cout[0]  = cout;
    assign sw_cout[1]  = s1_cout;
    assign sw_cout[2]  = s2_cout;
    assign sw_cout[3]  = s3_cout;
    assign sw_ovf[0]   = ovf;
    assign sw_ovf[1]   = s1_ovf;
    assign sw_ovf[2]   = s2_ovf;
    assign sw_ovf[3]   = s3_ovf;
    assign sw_sum[0]   = sum;
    assign sw_sum[1]   = {32'd0, s1_sum};
    assign sw_sum[2]   = {48'd0, s2_sum};
    assign sw_sum[3]   = s3_sum;

    // Reference: {ovf, cout, sum} for a w-bit add/subtract.
    function automatic logic [65:0] model(input int w, input logic [63:0] ta,
                                          input logic [63:0] tb, input logic tc, input logic ts);
        logic [63:0] m, am, be, sm;
        logic [64:0] r;
        logic        co, ov;
        m  = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
        am = ta & m;
        be = (ts ? ~tb : tb) & m;
        r  = {1'b0, am} + {1'b0, be} + {64'd0, tc ^ ts};
        co = r[w];
        sm = r[63:0] & m;
        ov = (am[w-1] == be[w-1]) && (sm[w-1] != am[w-1]);
        return {ov, co, sm};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [63:0] ta, input logic [63:0] tb, input logic tc,
                         input logic ts);
        a        = ta;
        b        = tb;
        cin      = tc;
        sub      = ts;
        in_valid = 1'b1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        tick(); tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        total++; if (sum !== 64'd0) begin bad++; $display("FAIL reset_sum: got %h want 0", sum); end
        total++; if (cout !== 1'b0 || ovf !== 1'b0) begin bad++; $display("FAIL reset_flags: got %b%b want 00", cout, ovf); end
        rst_n = 1'b1;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL idle_valid: got %b want 0", out_valid); end
    endtask

    task automatic test_add_wrap;
        issue(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0);
        tick();
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL wrap_early: got %b want 0", out_valid); end
        tick();
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL wrap_valid: got %b want 1", out_valid); end
        total++; if ({ovf, cout, sum} !== {1'b0, 1'b1, 64'd0})
            begin bad++; $display("FAIL wrap_result: got %b %b %h want 0 1 0", ovf, cout, sum); end
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL wrap_drain: got %b want 0", out_valid); end
    endtask

    task automatic test_back_to_back_sub;
        issue(64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b1);
        tick();
        issue(64'd3, 64'd5, 1'b0, 1'b1);
        tick();
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b1 || {ovf, cout, sum} !== {1'b1, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF})
            begin bad++; $display("FAIL sub_ovf: got v=%b %b %b %h want v=1 1 1 7fffffffffffffff", out_valid, ovf, cout, sum); end
        tick();
        total++; if (out_valid !== 1'b1 || {ovf, cout, sum} !== {1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE})
            begin bad++; $display("FAIL sub_borrow: got v=%b %b %b %h want v=1 0 0 fffffffffffffffe", out_valid, ovf, cout, sum); end
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL sub_no_dup: got %b want 0", out_valid); end
    endtask

    task automatic test_backpressure;
        logic [65:0] q[$];
        logic [65:0] held;
        logic        held_v, acc, del;
        int          sent, rcvd, occ;
        sent = 0; rcvd = 0; occ = 0; held_v = 1'b0; held = '0;
        for (int cyc = 0; cyc < 300 && rcvd < 10; cyc++) begin
            if (held_v) begin
                total++;
                if (out_valid !== 1'b1 || {ovf, cout, sum} !== held)
                    begin bad++; $display("FAIL bp_hold: got v=%b %h want v=1 %h", out_valid, {ovf, cout, sum}, held); end
            end
            out_ready = 1'($urandom_range(0, 1));
            if (sent < 10 && !in_valid)
                issue({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)));
            #1;
            total++;
            if (in_ready !== !(occ == MAIN_ST && !out_ready))
                begin bad++; $display("FAIL bp_in_ready: got %b want %b (occ=%0d)", in_ready, !(occ == MAIN_ST && !out_ready), occ); end
            acc = in_valid && in_ready;
            del = out_valid && out_ready;
            if (del) begin
                total++;
                if (q.size() == 0) begin
                    bad++; $display("FAIL bp_extra: got %h want nothing", {ovf, cout, sum});
                end else begin
                    if ({ovf, cout, sum} !== q[0])
                        begin bad++; $display("FAIL bp_data: got %h want %h", {ovf, cout, sum}, q[0]); end
                    void'(q.pop_front());
                end
                rcvd++;
            end
            held_v = out_valid && !out_ready;
            held   = {ovf, cout, sum};
            if (acc) begin
                q.push_back(model(64, a, b, cin, sub));
                sent++;
            end
            tick();
            occ = occ + int'(acc) - int'(del);
            if (acc) in_valid = 1'b0;
        end
        in_valid = 1'b0;
        total++; if (rcvd !== 10) begin bad++; $display("FAIL bp_count: got %0d want 10", rcvd); end
        out_ready = 1'b1;
        tick(); tick(); tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_drain: got %b want 0", out_valid); end
    endtask

    task automatic test_reset_midflight;
        logic seen;
        out_ready = 1'b0;
        issue(64'd100, 64'd23, 1'b0, 1'b0);
        tick();
        issue(64'd7, 64'd9, 1'b1, 1'b0);
        tick();
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL mid_pre_valid: got %b want 1", out_valid); end
        rst_n = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_drop: got %b want 0", out_valid); end
        #4;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        seen      = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (out_valid) seen = 1'b1;
        end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL mid_ghost: got %b want 0", seen); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL mid_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_sweep;
        logic [63:0] ea [N_SWEEP];
        logic [63:0] eb [N_SWEEP];
        logic        ec [N_SWEEP];
        logic        es [N_SWEEP];
        logic [65:0] exp_r, got_r;
        int          w [4];
        int          lat [4];
        int          idx;
        w   = '{64, 32, 16, 64};
        lat = '{2, 4, 1, 8};
        out_ready = 1'b1;
        in_valid  = 1'b0;
        rst_n     = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int j = 0; j < N_SWEEP + 9; j++) begin
            if (j < N_SWEEP) begin
                if (j % 8 == 0) begin
                    ea[j] = {64{1'b1}}; eb[j] = 64'd0; ec[j] = 1'b1; es[j] = 1'b0;
                end else if (j % 8 == 4) begin
                    ea[j] = 64'd0; eb[j] = 64'd0; ec[j] = 1'b1; es[j] = 1'b1;
                end else begin
                    ea[j] = {$urandom, $urandom}; eb[j] = {$urandom, $urandom};
                    ec[j] = 1'($urandom_range(0, 1)); es[j] = 1'($urandom_range(0, 1));
                end
                issue(ea[j], eb[j], ec[j], es[j]);
            end else begin
                in_valid = 1'b0;
            end
            tick();
            for (int i = 0; i < 4; i++) begin
                idx = j - lat[i] + 1;
                total++;
                if (idx >= 0 && idx < N_SWEEP) begin
                    exp_r = model(w[i], ea[idx], eb[idx], ec[idx], es[idx]);
                    got_r = {sw_ovf[i], sw_cout[i], sw_sum[i]};
                    if (sw_valid[i] !== 1'b1 || got_r !== exp_r)
                        begin bad++; $display("FAIL sweep%0d op%0d: got v=%b %h want v=1 %h", i, idx, sw_valid[i], got_r, exp_r); end
                end else if (sw_valid[i] !== 1'b0) begin
                    bad++; $display("FAIL sweep%0d idle cyc%0d: got v=%b want v=0", i, j, sw_valid[i]);
                end
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_add_wrap();
        test_back_to_back_sub();
        test_backpressure();
        test_reset_midflight();
        test_sweep();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
